// File: rtl/q2fsm_pkg.sv
// Shared types for the w/z stimulus transmitter, the sequence detector it drives,
// and any behavioural model of that detector.
package q2fsm_pkg;

  localparam int MIN_GAP = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  typedef enum logic [2:0] {
    DET_A = 3'd0,
    DET_B = 3'd1,
    DET_C = 3'd2,
    DET_D = 3'd3,
    DET_E = 3'd4,
    DET_F = 3'd5
  } det_state_t;

  // Detector transition table; z is asserted in E and F.
  function automatic det_state_t det_next(input det_state_t s, input logic w);
    det_state_t n;
    case (s)
      DET_A:   n = w ? DET_B : DET_A;
      DET_B:   n = w ? DET_C : DET_D;
      DET_C:   n = w ? DET_E : DET_D;
      DET_D:   n = w ? DET_F : DET_A;
      DET_E:   n = w ? DET_E : DET_D;
      DET_F:   n = w ? DET_C : DET_D;
      default: n = DET_A;
    endcase
    return n;
  endfunction

  function automatic logic det_z(input det_state_t s);
    return (s == DET_E) || (s == DET_F);
  endfunction

endpackage

// File: rtl/q2fsm_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module q2fsm_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/q2fsm_stim_tx.sv
// Serialises a parallel word onto w (MSB first), follows it with a zero gap,
// and counts the detector's z responses inside the frame window.
module q2fsm_stim_tx
  import q2fsm_pkg::tx_state_t;
  import q2fsm_pkg::MIN_GAP;
#(
  parameter int WORD_W = 16,
  parameter int GAP    = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              w,
  output logic              w_valid,
  input  logic              z,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  z_cnt
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  if (GAP < MIN_GAP) begin : g_gap_chk
    $error("q2fsm_stim_tx: GAP must be at least %0d", MIN_GAP);
  end
  if (WORD_W < 2) begin : g_word_chk
    $error("q2fsm_stim_tx: WORD_W must be at least 2");
  end

  tx_state_t         state_q, state_d;
  logic [WORD_W-2:0] shreg_q, shreg_d;   // MSB is already on w when loaded
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              w_q, w_d;
  logic              w_valid_q, w_valid_d;
  logic              busy_q, busy_d;
  logic              z_win_q, z_win_d;
  logic              done_q, done_d;
  logic              cnt_clr;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    w_d       = 1'b0;
    w_valid_d = 1'b0;
    busy_d    = busy_q;
    cnt_clr   = 1'b0;
    // z_win tracks the detector's one-cycle registered response to w.
    z_win_d   = w_valid_q;
    done_d    = z_win_q & ~w_valid_q;

    case (state_q)
      q2fsm_pkg::IDLE: begin
        if (in_valid) begin
          shreg_d   = in_data[WORD_W-2:0];
          w_d       = in_data[WORD_W-1];
          w_valid_d = 1'b1;
          bit_cnt_d = BW'(WORD_W - 1);
          busy_d    = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = q2fsm_pkg::SHIFT;
        end
      end
      q2fsm_pkg::SHIFT: begin
        if (bit_cnt_q != '0) begin
          w_d       = shreg_q[WORD_W-2];
          w_valid_d = 1'b1;
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - BW'(1);
        end else begin
          gap_cnt_d = GW'(GAP - 1);
          state_d   = q2fsm_pkg::GAP;
        end
      end
      q2fsm_pkg::GAP: begin
        if (gap_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = q2fsm_pkg::IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = q2fsm_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= q2fsm_pkg::IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      z_win_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      z_win_q   <= z_win_d;
      done_q    <= done_d;
    end
  end

  q2fsm_sat_cnt #(
    .W (CNT_W)
  ) u_z_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (z_win_q & z),
    .cnt     (z_cnt)
  );

  assign in_ready = (state_q == q2fsm_pkg::IDLE);
  assign w        = w_q;
  assign w_valid  = w_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_q2fsm_stim_tx.sv
// Loopback bench: two transmitters (8-bit and 3-bit counters) drive a detector
// model; expected z counts are queued at drive time and checked on done.
module tb_q2fsm_stim_tx;
  import q2fsm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        force_z = 1'b0;
  logic        z;

  logic        in_ready, w, w_valid, busy, done;
  logic [7:0]  z_cnt;
  logic        in_ready3, w3, w_valid3, busy3, done3;
  logic [2:0]  z_cnt3;

  typedef struct {
    int    c8;
    int    c3;
    string tag;
  } exp_t;

  exp_t       sb_q[$];
  int         acc_q[$];
  int         done_edge_q[$];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         n_done = 0;
  det_state_t det_q;

  always #5 clk = ~clk;

  q2fsm_stim_tx #(.WORD_W(16), .GAP(2), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w(w), .w_valid(w_valid), .z(z), .busy(busy),
    .done(done), .z_cnt(z_cnt)
  );

  q2fsm_stim_tx #(.WORD_W(16), .GAP(2), .CNT_W(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .w(w3), .w_valid(w_valid3), .z(z), .busy(busy3),
    .done(done3), .z_cnt(z_cnt3)
  );

  // Registered (Moore) detector model fed from the 8-bit transmitter's w.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) det_q <= DET_A;
    else          det_q <= det_next(det_q, w);
  end
  assign z = force_z | det_z(det_q);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && in_valid && in_ready) acc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      done_edge_q.push_back(cyc - 1);
      n_done++;
      if (sb_q.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_z_cnt"}, z_cnt, e.c8);
        check({e.tag, "_z_cnt_w3"}, z_cnt3, e.c3);
        $display("frame %s: z_cnt=%0d z_cnt_w3=%0d", e.tag, z_cnt, z_cnt3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at 1 time unit after the edge on which acceptance number n occurs.
  task automatic wait_acc(input int n, input string tag);
    int t;
    t = 0;
    while (acc_q.size() < n && t < 60) begin
      tick();
      t++;
    end
    check({tag, "_accept"}, acc_q.size() >= n, 1);
  endtask

  task automatic push_exp(input int c8, input int c3, input string tag);
    exp_t e;
    e.c8 = c8;
    e.c3 = c3;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Called just after the acceptance edge; samples after edges 0..19.
  task automatic observe_frame(input logic [15:0] data, input string tag);
    logic [15:0] bits;
    int wv, rdy, nd0;
    wv = 0;
    rdy = 0;
    bits = '0;
    nd0 = done_edge_q.size();
    check({tag, "_first_bit"}, {w_valid, w}, {1'b1, data[15]});
    for (int k = 0; k < 20; k++) begin
      if (k < 16) bits[15-k] = w;
      wv += int'(w_valid);
      if (k < 18) rdy += int'(in_ready);
      if (k == 17) check({tag, "_busy_gap2"}, busy, 1);
      if (k == 18) check({tag, "_busy_idle"}, busy, 0);
      if (k == 10) check({tag, "_w3_match"}, {w3, w_valid3, busy3, in_ready3}, {w, w_valid, busy, in_ready});
      tick();
    end
    check({tag, "_w_bits"}, bits, data);
    check({tag, "_w_valid_cycles"}, wv, 16);
    check({tag, "_ready_low"}, rdy, 0);
    check({tag, "_done_count"}, done_edge_q.size(), nd0 + 1);
    if (done_edge_q.size() > nd0)
      check({tag, "_done_latency"}, done_edge_q[$] - acc_q[$], 17);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n0, rdy, t;
    // Reset values before any clock edge
    #2;
    check("rst_outputs", {w, w_valid, busy, done, in_ready}, 5'b00001);
    check("rst_z_cnt", z_cnt, 0);
    check("rst_z_cnt_w3", z_cnt3, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single frame 16'hD000: one z response
    in_data = 16'hD000;
    in_valid = 1'b1;
    push_exp(1, 1, "d000");
    n0 = acc_q.size();
    wait_acc(n0 + 1, "d000");
    in_valid = 1'b0;
    $display("accept d000 at edge %0d", acc_q[$]);
    observe_frame(16'hD000, "d000");

    // Single frame 16'hFFFF: 14 responses, 3-bit counter saturates at 7
    in_data = 16'hFFFF;
    in_valid = 1'b1;
    push_exp(14, 7, "ffff");
    n0 = acc_q.size();
    wait_acc(n0 + 1, "ffff");
    in_valid = 1'b0;
    $display("accept ffff at edge %0d", acc_q[$]);
    observe_frame(16'hFFFF, "ffff");
    check("det_back_to_A", det_q, DET_A);

    // Back-to-back frames with in_valid held high
    in_data = 16'hD000;
    in_valid = 1'b1;
    push_exp(1, 1, "b2b_d000");
    n0 = acc_q.size();
    wait_acc(n0 + 1, "b2b_first");
    in_data = 16'hFFFF;
    push_exp(14, 7, "b2b_ffff");
    rdy = 0;
    t = 0;
    while (acc_q.size() < n0 + 2 && t < 40) begin
      rdy += int'(in_ready);
      tick();
      t++;
    end
    in_valid = 1'b0;
    check("b2b_second_accept", acc_q.size(), n0 + 2);
    if (acc_q.size() >= n0 + 2) begin
      check("b2b_period", acc_q[n0+1] - acc_q[n0], 19);
      $display("b2b accepts at edges %0d and %0d", acc_q[n0], acc_q[n0+1]);
    end
    check("b2b_ready_cycles", rdy, 1);
    repeat (22) tick();

    // z forced high while idle and during the first w_valid cycle
    force_z = 1'b1;
    repeat (3) tick();
    check("idle_z_ignored", z_cnt, 14);
    in_data = 16'h0000;
    in_valid = 1'b1;
    push_exp(0, 0, "zero_forced");
    n0 = acc_q.size();
    wait_acc(n0 + 1, "zero_forced");
    in_valid = 1'b0;
    check("accept_clears_cnt", z_cnt, 0);
    tick();
    check("first_wvalid_z_ignored", z_cnt, 0);
    force_z = 1'b0;
    repeat (22) tick();

    // Reset pulse part-way through a frame
    in_data = 16'hFFFF;
    in_valid = 1'b1;
    n0 = acc_q.size();
    wait_acc(n0 + 1, "rst_frame");
    in_valid = 1'b0;
    repeat (5) tick();
    check("pre_reset_cnt", z_cnt, 2);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_outputs", {w, w_valid, busy, done, in_ready}, 5'b00001);
    check("async_rst_z_cnt", z_cnt, 0);
    in_data = 16'hD000;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push_exp(1, 1, "post_rst_d000");
    n0 = acc_q.size();
    tick();
    in_valid = 1'b0;
    check("accept_after_release", acc_q.size(), n0 + 1);
    repeat (24) tick();

    check("total_done_pulses", n_done, 6);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
